tetris_key_commander: RTL and testbench

Converts filtered PS/2 key events (make/break with scan code) from the keyboard press driver into single-cycle Tetris game command pulses. Left, right and soft-drop auto-repeat while held (initial delay, then fixed-rate repeat); rotate and hard-drop fire once per press. Sits between the keyboard press driver and the game-logic controller, all in the `clk` domain.

---
 rtl/tetris_keys_pkg.sv | 40 ++++
 rtl/key_repeat_fsm.sv | 115 +++++++++++
 rtl/tetris_key_commander.sv | 180 ++++++++++++++++++
 tb/tb_tetris_key_commander.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_keys_pkg.sv
// -----------------------------------------------------------------------------
// tetris_keys_pkg
// Shared constants for the Tetris key commander:
//   - set-2 scan codes of the five game keys (E0/F0 prefixes already removed)
//   - encoding of the auto-repeat FSM states
//   - bit positions inside the `held` status vector
//   - a small scan-code match helper used by the decode logic
// -----------------------------------------------------------------------------
package tetris_keys_pkg;

    // Scan codes of the mapped keys
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_SPACE = 8'h29;

    // Auto-repeat FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // Bit positions inside the `held` status vector
    localparam int unsigned HELD_LEFT   = 0;
    localparam int unsigned HELD_RIGHT  = 1;
    localparam int unsigned HELD_SOFT   = 2;
    localparam int unsigned HELD_ROTATE = 3;
    localparam int unsigned HELD_HARD   = 4;
    localparam int unsigned HELD_W      = 5;

    // True when a qualified key event carries the given scan code
    function automatic logic key_hit(
        input logic       evt,
        input logic [7:0] code,
        input logic [7:0] key
    );
        return evt & (code == key);
    endfunction

endpackage : tetris_keys_pkg

// File: rtl/key_repeat_fsm.sv
// -----------------------------------------------------------------------------
// key_repeat_fsm
// Auto-repeat engine for one held key (IDLE -> DELAY -> REPEAT).
// A press from IDLE fires a pulse immediately, a second pulse DAS_DELAY
// cycles later, then one every ARR_PERIOD cycles while the key stays held.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   press        key make event (single cycle)
//   release_key  key break event (single cycle)
//   cancel       forced return to IDLE (game disabled or opposing key pressed)
//   pulse        registered single-cycle command pulse
//   held         registered "FSM not idle" status
// -----------------------------------------------------------------------------
module key_repeat_fsm
    import tetris_keys_pkg::*;
#(
    parameter int unsigned DAS_DELAY  = 8_000_000,
    parameter int unsigned ARR_PERIOD = 2_500_000,
    parameter int unsigned CNT_W      = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic press,
    input  logic release_key,
    input  logic cancel,
    output logic pulse,
    output logic held
);

    // Counters count down to zero, so the loaded value is one less than
    // the wanted spacing between pulses.
    localparam logic [CNT_W-1:0] DAS_LOAD = CNT_W'(DAS_DELAY - 1);
    localparam logic [CNT_W-1:0] ARR_LOAD = CNT_W'(ARR_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             pulse_r;
    logic             pulse_nxt_s;
    logic             held_r;

    // Next state, counter reload/decrement and pulse decision
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        pulse_nxt_s = 1'b0;
        if (cancel || release_key) begin
            // Leaving the key takes priority and never produces a pulse
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (press) begin
                        pulse_nxt_s = 1'b1;
                        cnt_nxt_s   = DAS_LOAD;
                        state_nxt_s = ST_DELAY;
                    end else begin
                        cnt_nxt_s   = CNT_ZERO;
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_DELAY: begin
                    // A repeated make while held is ignored: no restart
                    if (cnt_r == CNT_ZERO) begin
                        pulse_nxt_s = 1'b1;
                        cnt_nxt_s   = ARR_LOAD;
                        state_nxt_s = ST_REPEAT;
                    end else begin
                        cnt_nxt_s   = cnt_r - CNT_ONE;
                        state_nxt_s = ST_DELAY;
                    end
                end
                ST_REPEAT: begin
                    if (cnt_r == CNT_ZERO) begin
                        pulse_nxt_s = 1'b1;
                        cnt_nxt_s   = ARR_LOAD;
                    end else begin
                        cnt_nxt_s   = cnt_r - CNT_ONE;
                    end
                    state_nxt_s = ST_REPEAT;
                end
                default: begin
                    // Unused encoding recovers to IDLE
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            pulse_r <= 1'b0;
            held_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            pulse_r <= pulse_nxt_s;
            held_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    assign pulse = pulse_r;
    assign held  = held_r;

endmodule : key_repeat_fsm

// File: rtl/tetris_key_commander.sv
// -----------------------------------------------------------------------------
// tetris_key_commander
// Turns filtered PS/2 make/break events into single-cycle Tetris commands.
// Left, right and soft drop auto-repeat while held; rotate and hard drop fire
// once per press. Left and right cancel each other on make.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset
//   valid          one-cycle key event strobe
//   makeBreak      1 = make, 0 = break (qualified by valid)
//   outCode        set-2 scan code (qualified by valid)
//   enable         game accepting input; low forces every key idle
//   cmd_left       left command pulse
//   cmd_right      right command pulse
//   cmd_soft_drop  soft-drop command pulse
//   cmd_rotate     rotate command pulse
//   cmd_hard_drop  hard-drop command pulse
//   held           {hard_drop, rotate, soft_drop, right, left} held status
// -----------------------------------------------------------------------------
module tetris_key_commander
    import tetris_keys_pkg::*;
#(
    parameter int unsigned DAS_DELAY  = 8_000_000,
    parameter int unsigned ARR_PERIOD = 2_500_000,
    parameter int unsigned CNT_W      = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic              makeBreak,
    input  logic [7:0]        outCode,
    input  logic              enable,
    output logic              cmd_left,
    output logic              cmd_right,
    output logic              cmd_soft_drop,
    output logic              cmd_rotate,
    output logic              cmd_hard_drop,
    output logic [HELD_W-1:0] held
);

    // Events are dropped entirely while the game is not accepting input
    logic make_s;
    logic brk_s;

    logic press_left_s;
    logic press_right_s;
    logic press_soft_s;
    logic press_rot_s;
    logic press_hard_s;
    logic brk_left_s;
    logic brk_right_s;
    logic brk_soft_s;
    logic brk_rot_s;
    logic brk_hard_s;

    logic cancel_left_s;
    logic cancel_right_s;
    logic cancel_soft_s;

    logic left_pulse_s;
    logic right_pulse_s;
    logic soft_pulse_s;
    logic left_held_s;
    logic right_held_s;
    logic soft_held_s;

    logic rot_held_r;
    logic rot_pulse_r;
    logic hard_held_r;
    logic hard_pulse_r;

    assign make_s = valid & enable & makeBreak;
    assign brk_s  = valid & enable & ~makeBreak;

    assign press_left_s  = key_hit(make_s, outCode, KEY_LEFT);
    assign press_right_s = key_hit(make_s, outCode, KEY_RIGHT);
    assign press_soft_s  = key_hit(make_s, outCode, KEY_DOWN);
    assign press_rot_s   = key_hit(make_s, outCode, KEY_UP);
    assign press_hard_s  = key_hit(make_s, outCode, KEY_SPACE);
    assign brk_left_s    = key_hit(brk_s, outCode, KEY_LEFT);
    assign brk_right_s   = key_hit(brk_s, outCode, KEY_RIGHT);
    assign brk_soft_s    = key_hit(brk_s, outCode, KEY_DOWN);
    assign brk_rot_s     = key_hit(brk_s, outCode, KEY_UP);
    assign brk_hard_s    = key_hit(brk_s, outCode, KEY_SPACE);

    // Pressing one horizontal direction abandons the other; the abandoned
    // key only comes back on its own fresh make.
    assign cancel_left_s  = ~enable | press_right_s;
    assign cancel_right_s = ~enable | press_left_s;
    assign cancel_soft_s  = ~enable;

    key_repeat_fsm #(
        .DAS_DELAY  (DAS_DELAY),
        .ARR_PERIOD (ARR_PERIOD),
        .CNT_W      (CNT_W)
    ) u_left (
        .clk         (clk),
        .reset       (reset),
        .press       (press_left_s),
        .release_key (brk_left_s),
        .cancel      (cancel_left_s),
        .pulse       (left_pulse_s),
        .held        (left_held_s)
    );

    key_repeat_fsm #(
        .DAS_DELAY  (DAS_DELAY),
        .ARR_PERIOD (ARR_PERIOD),
        .CNT_W      (CNT_W)
    ) u_right (
        .clk         (clk),
        .reset       (reset),
        .press       (press_right_s),
        .release_key (brk_right_s),
        .cancel      (cancel_right_s),
        .pulse       (right_pulse_s),
        .held        (right_held_s)
    );

    key_repeat_fsm #(
        .DAS_DELAY  (DAS_DELAY),
        .ARR_PERIOD (ARR_PERIOD),
        .CNT_W      (CNT_W)
    ) u_soft (
        .clk         (clk),
        .reset       (reset),
        .press       (press_soft_s),
        .release_key (brk_soft_s),
        .cancel      (cancel_soft_s),
        .pulse       (soft_pulse_s),
        .held        (soft_held_s)
    );

    // One-shot held flags and their single pulse per press
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rot_held_r   <= 1'b0;
            rot_pulse_r  <= 1'b0;
            hard_held_r  <= 1'b0;
            hard_pulse_r <= 1'b0;
        end else if (!enable) begin
            rot_held_r   <= 1'b0;
            rot_pulse_r  <= 1'b0;
            hard_held_r  <= 1'b0;
            hard_pulse_r <= 1'b0;
        end else begin
            // Auto-repeated makes from the keyboard are absorbed by the flag
            rot_pulse_r  <= press_rot_s & ~rot_held_r;
            hard_pulse_r <= press_hard_s & ~hard_held_r;
            if (press_rot_s) begin
                rot_held_r <= 1'b1;
            end else if (brk_rot_s) begin
                rot_held_r <= 1'b0;
            end else begin
                rot_held_r <= rot_held_r;
            end
            if (press_hard_s) begin
                hard_held_r <= 1'b1;
            end else if (brk_hard_s) begin
                hard_held_r <= 1'b0;
            end else begin
                hard_held_r <= hard_held_r;
            end
        end
    end

    assign cmd_left      = left_pulse_s;
    assign cmd_right     = right_pulse_s;
    assign cmd_soft_drop = soft_pulse_s;
    assign cmd_rotate    = rot_pulse_r;
    assign cmd_hard_drop = hard_pulse_r;

    assign held[HELD_LEFT]   = left_held_s;
    assign held[HELD_RIGHT]  = right_held_s;
    assign held[HELD_SOFT]   = soft_held_s;
    assign held[HELD_ROTATE] = rot_held_r;
    assign held[HELD_HARD]   = hard_held_r;

endmodule : tetris_key_commander

// File: tb/tb_tetris_key_commander.sv
// -----------------------------------------------------------------------------
// tb_tetris_key_commander
// Directed scenarios plus randomized key traffic, compared every cycle against
// a reference model that tracks each key as "held since cycle S" and derives
// pulses from elapsed time: first pulse at S, then S+DAS, S+DAS+ARR, ...
// -----------------------------------------------------------------------------
module tb_tetris_key_commander;

    localparam int DAS = 10;
    localparam int ARR = 4;

    logic       clk;
    logic       reset;
    logic       valid;
    logic       makeBreak;
    logic [7:0] outCode;
    logic       enable;
    logic       cmd_left;
    logic       cmd_right;
    logic       cmd_soft_drop;
    logic       cmd_rotate;
    logic       cmd_hard_drop;
    logic [4:0] held;

    tetris_key_commander #(
        .DAS_DELAY  (DAS),
        .ARR_PERIOD (ARR),
        .CNT_W      (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .valid         (valid),
        .makeBreak     (makeBreak),
        .outCode       (outCode),
        .enable        (enable),
        .cmd_left      (cmd_left),
        .cmd_right     (cmd_right),
        .cmd_soft_drop (cmd_soft_drop),
        .cmd_rotate    (cmd_rotate),
        .cmd_hard_drop (cmd_hard_drop),
        .held          (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    logic [7:0] rep_code [3] = '{8'h6B, 8'h74, 8'h72};
    logic [7:0] one_code [2] = '{8'h75, 8'h29};
    bit         act   [3];
    int         start [3];
    bit         flag  [2];
    logic [4:0] exp_cmd;
    logic [4:0] exp_held;

    int left_cnt, right_cnt, soft_cnt, rot_cnt, hard_cnt;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            act[k]   = 1'b0;
            start[k] = 0;
        end
        flag[0]  = 1'b0;
        flag[1]  = 1'b0;
        exp_cmd  = 5'd0;
        exp_held = 5'd0;
    endtask

    // Advance the model by one clock edge with the inputs sampled at that edge
    task automatic model_step(input bit v, input bit mb, input logic [7:0] code,
                              input bit en, input bit rn);
        bit mk [3];
        bit bk [3];
        bit cancel;
        int d;
        cyc++;
        exp_cmd = 5'd0;
        if (!rn || !en) begin
            model_clear();
        end else begin
            for (int k = 0; k < 3; k++) begin
                mk[k] = v && mb && (code == rep_code[k]);
                bk[k] = v && !mb && (code == rep_code[k]);
            end
            for (int k = 0; k < 3; k++) begin
                cancel = (k == 0 && mk[1]) || (k == 1 && mk[0]);
                if (act[k] && (bk[k] || cancel)) begin
                    act[k] = 1'b0;
                end else if (!act[k] && mk[k]) begin
                    act[k]     = 1'b1;
                    start[k]   = cyc;
                    exp_cmd[k] = 1'b1;
                end else if (act[k]) begin
                    d = cyc - start[k];
                    if (d >= DAS && ((d - DAS) % ARR) == 0) exp_cmd[k] = 1'b1;
                end
            end
            for (int j = 0; j < 2; j++) begin
                if (v && mb && code == one_code[j] && !flag[j]) begin
                    flag[j]        = 1'b1;
                    exp_cmd[3 + j] = 1'b1;
                end else if (v && !mb && code == one_code[j]) begin
                    flag[j] = 1'b0;
                end
            end
            exp_held = {flag[1], flag[0], act[2], act[1], act[0]};
        end
    endtask

    // One clock: drive inputs at the falling edge, model at the rising edge,
    // compare at the next falling edge
    task automatic drive(input bit v, input bit mb, input logic [7:0] code, input bit en);
        valid     = v;
        makeBreak = mb;
        outCode   = code;
        enable    = en;
        @(posedge clk);
        model_step(v, mb, code, en, reset);
        @(negedge clk);
        check_eq("cmd", {27'd0, cmd_hard_drop, cmd_rotate, cmd_soft_drop, cmd_right, cmd_left},
                 {27'd0, exp_cmd});
        check_eq("held", {27'd0, held}, {27'd0, exp_held});
        left_cnt  += int'(cmd_left);
        right_cnt += int'(cmd_right);
        soft_cnt  += int'(cmd_soft_drop);
        rot_cnt   += int'(cmd_rotate);
        hard_cnt  += int'(cmd_hard_drop);
    endtask

    task automatic idle(input int n, input bit en);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, en);
    endtask

    task automatic clear_counts();
        left_cnt = 0; right_cnt = 0; soft_cnt = 0; rot_cnt = 0; hard_cnt = 0;
    endtask

    task automatic oneshot_scenario(input logic [7:0] code, input string tag);
        clear_counts();
        drive(1'b1, 1'b1, code, 1'b1);
        idle(4, 1'b1);
        drive(1'b1, 1'b1, code, 1'b1);
        idle(2, 1'b1);
        drive(1'b1, 1'b0, code, 1'b1);
        idle(2, 1'b1);
        drive(1'b1, 1'b1, code, 1'b1);
        idle(2, 1'b1);
        drive(1'b1, 1'b0, code, 1'b1);
        idle(2, 1'b1);
        check_eq(tag, (code == 8'h75) ? rot_cnt : hard_cnt, 32'd2);
    endtask

    initial begin
        bit         en_r;
        bit         v_r;
        bit         mb_r;
        logic [7:0] code_r;
        int         pick;

        model_clear();
        clear_counts();
        reset     = 1'b0;
        valid     = 1'b0;
        makeBreak = 1'b0;
        outCode   = 8'h00;
        enable    = 1'b1;
        @(negedge clk);

        // Power-up reset held for three cycles
        idle(3, 1'b1);
        reset = 1'b1;
        idle(3, 1'b1);

        // Left: make at cycle 0, break at cycle 30
        clear_counts();
        drive(1'b1, 1'b1, 8'h6B, 1'b1);
        idle(29, 1'b1);
        drive(1'b1, 1'b0, 8'h6B, 1'b1);
        idle(10, 1'b1);
        check_eq("left_pulses", left_cnt, 32'd6);

        // One-shot keys ignore repeated makes until released
        oneshot_scenario(8'h75, "rotate_pulses");
        oneshot_scenario(8'h29, "hard_pulses");

        // Right make while left repeats cancels left for good
        drive(1'b1, 1'b1, 8'h6B, 1'b1);
        idle(20, 1'b1);
        clear_counts();
        drive(1'b1, 1'b1, 8'h74, 1'b1);
        idle(20, 1'b1);
        check_eq("left_cancelled", left_cnt, 32'd0);
        check_eq("right_pulses", right_cnt, 32'd4);
        check_eq("left_idle", {31'd0, held[0]}, 32'd0);
        drive(1'b1, 1'b0, 8'h74, 1'b1);
        drive(1'b1, 1'b0, 8'h6B, 1'b1);
        idle(3, 1'b1);

        // Soft drop interrupted by enable low for cycles 5..7
        clear_counts();
        drive(1'b1, 1'b1, 8'h72, 1'b1);
        idle(4, 1'b1);
        idle(3, 1'b0);
        idle(20, 1'b1);
        check_eq("soft_pulses", soft_cnt, 32'd1);
        check_eq("soft_held", {27'd0, held}, 32'd0);

        // Unmapped code and a stray break are ignored
        clear_counts();
        drive(1'b1, 1'b1, 8'h1C, 1'b1);
        drive(1'b1, 1'b0, 8'h6B, 1'b1);
        idle(12, 1'b1);
        check_eq("stray_pulses", left_cnt + right_cnt + soft_cnt + rot_cnt + hard_cnt, 32'd0);

        // Asynchronous reset during left repeat
        drive(1'b1, 1'b1, 8'h6B, 1'b1);
        idle(15, 1'b1);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_cmd", {27'd0, cmd_hard_drop, cmd_rotate, cmd_soft_drop, cmd_right, cmd_left}, 32'd0);
        check_eq("arst_held", {27'd0, held}, 32'd0);
        model_clear();
        @(negedge clk);
        idle(2, 1'b1);
        reset = 1'b1;
        idle(12, 1'b1);

        // Randomized traffic with occasional enable drops
        en_r = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (en_r) en_r = ($urandom_range(0, 199) != 0);
            else      en_r = ($urandom_range(0, 4) == 0);
            v_r  = ($urandom_range(0, 9) == 0);
            mb_r = ($urandom_range(0, 1) == 1);
            pick = $urandom_range(0, 6);
            case (pick)
                0: code_r = 8'h6B;
                1: code_r = 8'h74;
                2: code_r = 8'h72;
                3: code_r = 8'h75;
                4: code_r = 8'h29;
                5: code_r = 8'($urandom_range(0, 255));
                default: code_r = (i % 2 == 0) ? 8'h6B : 8'h74;
            endcase
            drive(v_r, mb_r, code_r, en_r);
        end
        idle(5, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stuck simulation
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_tetris_key_commander
